// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts A, B, cin, adds one bit per clock LSB first,
// and holds sum/cout/ovf until the consumer takes them.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid and ready
  // are both high; in_ready is high only in IDLE, out_valid only in DONE.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_sum, cell_carry;
  logic             last_bit;

  fa_cell u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {cell_sum, sum_q[WIDTH-1:1]};
        carry_d = cell_carry;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q is the carry into the MSB on this final step.
          cout_d  = cell_carry;
          ovf_d   = carry_q ^ cell_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a reset that is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operand request is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH, the addend A.
REQ-007 The block SHALL have port b, input, WIDTH, the addend B.
REQ-008 The block SHALL have port cin, input, 1, the carry-in.
REQ-009 The block SHALL have port out_valid, output, 1, meaning a result is held on the outputs.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH, the result bits (A+B+cin) mod 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1, the carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1, the signed overflow flag, equal to (carry into MSB) XOR cout.
REQ-014 The block SHALL have port busy, output, 1, which is high in the RUN and DONE states.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, a clock edge with in_valid=1 SHALL capture a, b and cin into the A shift register, B shift register and carry register, clear the bit counter, and enter RUN.
REQ-018 In IDLE with in_valid=0, the FSM SHALL stay in IDLE and the registers SHALL hold.
REQ-019 On each RUN edge, the one-bit cell SHALL add the A LSB, the B LSB and the carry register.
- The sum bit SHALL be shifted into the sum register MSB, and the sum register shifted right.
- The A and B registers SHALL be shifted right.
- The carry register SHALL take the cell carry.
- The counter SHALL increment.
REQ-020 On the RUN edge where counter==WIDTH-1, the carry into the MSB SHALL be captured for ovf, and the FSM SHALL enter DONE.
REQ-021 out_valid SHALL rise exactly WIDTH clock edges after the accepting edge.
REQ-022 In DONE, sum, cout and ovf SHALL hold stable until an edge with out_ready=1, after which the FSM SHALL return to IDLE.
REQ-023 in_valid in RUN or DONE SHALL be ignored, with no capture, including in DONE with out_ready=1 on the same edge.
REQ-024 Peak throughput SHALL be one addition per WIDTH+2 cycles.
REQ-025 sum, cout and ovf SHALL retain the last result in IDLE until the next RUN overwrites them.
REQ-026 Operands whose sum wraps (e.g. all-ones + 1) SHALL produce sum=0 and cout=1, with no saturation.

Reset
REQ-027 While rst=1, regardless of clk, the block SHALL force:
- state=IDLE;
- all shift registers, the counter and the carry register = 0;
- sum=0, cout=0, ovf=0, out_valid=0, busy=0.
REQ-028 in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-029 A reset asserted during RUN or DONE SHALL abort the operation, and no result SHALL be presented afterward.

Structure
REQ-030 Package serial_adder_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the constant DEFAULT_WIDTH=8;
- the counter-width function clog2(WIDTH).
REQ-031 The block SHALL instantiate one combinational sub-module fa_cell (inputs a, b, c; outputs sum, carry) as the sole arithmetic element, with no '+' operator on the data path.

Verification
REQ-032 Scenario (WIDTH=8): a=0x5A, b=0x3C, cin=0 -> out_valid 8 edges after accept, sum=0x96, cout=0, ovf=1.
REQ-033 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; and a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-034 Scenario: a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
REQ-035 Scenario: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs stable and in_ready=0; out_ready=1 -> IDLE next edge, then the new request is accepted.
REQ-036 Scenario: assert rst at RUN bit 3 -> all outputs 0 immediately; after release in_ready=1 and no out_valid until a fresh request.
REQ-037 Scenario: 1000 random back-to-back requests with random out_ready -> every result matches a+b+cin, with latency per REQ-021.
